// File: rtl/bus_xfer_ctrl.sv
// ---------------------------------------------------------------------------
// bus_xfer_ctrl
//
// Round-robin sequencer/arbiter for the shared 8-bit register bus. It grants
// one register-to-register transfer at a time and drives the one-hot output
// enables (oa) and write enables (wa) of the bus-attached registers. It never
// touches data itself.
//
// Transfer sequence: IDLE -> DRIVE -> WRITE -> DONE -> IDLE.
//   DRIVE : oa[src] only, so the bus settles before the write.
//   WRITE : oa[src] and wa[dst]; the destination latches at the closing edge.
//   DONE  : ack[grant] pulses for one cycle.
//
// Optional feature (macro BUSXFER_NOSETTLE_EN): the DRIVE state is skipped.
// IDLE goes straight to WRITE, giving ack one cycle earlier and one transfer
// every 3 cycles instead of 4.
//
// Parameters:
//   NREG - number of registers on the bus (>= 2)
//   NREQ - number of requesters
//   IW   - register index width, $clog2(NREG)
//
// Ports:
//   clk   - clock, all state updates on posedge
//   clr_n - asynchronous active-low reset
//   req   - per-requester request level, held until that requester's ack
//   src   - packed source indices, requester i uses [i*IW +: IW]
//   dst   - packed destination indices, same packing as src
//   ack   - one-cycle completion pulse to the granted requester
//   oa    - one-hot register output enables
//   wa    - one-hot register write enables
//   busy  - high whenever the FSM is not IDLE
//   err   - sticky out-of-range index flag, cleared only by reset
// ---------------------------------------------------------------------------
module bus_xfer_ctrl #(
    parameter  int NREG = 8,
    parameter  int NREQ = 4,
    localparam int IW   = $clog2(NREG),
    localparam int GW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic               clk,
    input  logic               clr_n,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ*IW-1:0] src,
    input  logic [NREQ*IW-1:0] dst,
    output logic [NREQ-1:0]    ack,
    output logic [NREG-1:0]    oa,
    output logic [NREG-1:0]    wa,
    output logic               busy,
    output logic               err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    // State entered on a grant.
`ifdef BUSXFER_NOSETTLE_EN
    localparam state_t FIRST = WRITE;
`else
    localparam state_t FIRST = DRIVE;
`endif

    state_t          state_q, state_d;
    logic [GW-1:0]   ptr_q, ptr_d;      // last granted requester
    logic [GW-1:0]   gnt_q, gnt_d;      // requester of the transfer in flight
    logic [IW-1:0]   src_q, src_d;
    logic [IW-1:0]   dst_q, dst_d;
    logic            err_d;
    logic [NREG-1:0] oa_d, wa_d;
    logic [NREQ-1:0] ack_d;
    logic            busy_d;

    // Arbiter results.
    logic            win_any;
    logic [GW-1:0]   win_idx;
    logic [IW-1:0]   win_src, win_dst;

    // One-hot register select; an index >= NREG matches nothing.
    function automatic logic [NREG-1:0] reg_sel(input logic [IW-1:0] idx);
        logic [NREG-1:0] sel;
        sel = '0;
        for (int r = 0; r < NREG; r++) begin
            sel[r] = (idx == IW'(r));
        end
        return sel;
    endfunction

    // Round-robin search starting at ptr+1: the first requester above the
    // pointer wins; if there is none, the first one at or below it wins.
    logic            hi_found, lo_found;
    logic [GW-1:0]   hi_idx, lo_idx;
    logic [IW-1:0]   hi_src, hi_dst, lo_src, lo_dst;

    // NOTE: every variable written in a combinational block gets a default
    // first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        hi_found = 1'b0;
        lo_found = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        hi_src   = '0;
        hi_dst   = '0;
        lo_src   = '0;
        lo_dst   = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (req[i]) begin
                if (i > int'(ptr_q)) begin
                    if (!hi_found) begin
                        hi_found = 1'b1;
                        hi_idx   = GW'(i);
                        hi_src   = src[i*IW +: IW];
                        hi_dst   = dst[i*IW +: IW];
                    end
                end else if (!lo_found) begin
                    lo_found = 1'b1;
                    lo_idx   = GW'(i);
                    lo_src   = src[i*IW +: IW];
                    lo_dst   = dst[i*IW +: IW];
                end
            end
        end
        win_any = hi_found | lo_found;
        win_idx = hi_found ? hi_idx : lo_idx;
        win_src = hi_found ? hi_src : lo_src;
        win_dst = hi_found ? hi_dst : lo_dst;
    end

    // Next state, captured transfer, and next values of the registered
    // outputs (decoded from the next state so they line up with it).
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gnt_d   = gnt_q;
        src_d   = src_q;
        dst_d   = dst_q;
        err_d   = err;

        case (state_q)
            IDLE: begin
                if (win_any) begin
                    state_d = FIRST;
                    ptr_d   = win_idx;
                    gnt_d   = win_idx;
                    src_d   = win_src;
                    dst_d   = win_dst;
                    if (reg_sel(win_src) == '0 || reg_sel(win_dst) == '0) begin
                        err_d = 1'b1;
                    end
                end
            end
            DRIVE:   state_d = WRITE;
            WRITE:   state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        oa_d  = '0;
        wa_d  = '0;
        ack_d = '0;
        case (state_d)
            DRIVE: oa_d = reg_sel(src_d);
            WRITE: begin
                oa_d = reg_sel(src_d);
                wa_d = reg_sel(dst_d);
            end
            DONE: begin
                for (int i = 0; i < NREQ; i++) begin
                    ack_d[i] = (gnt_d == GW'(i));
                end
            end
            default: ;
        endcase
        busy_d = (state_d != IDLE);
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q <= IDLE;
            ptr_q   <= GW'(NREQ - 1);   // requester 0 wins first after reset
            gnt_q   <= '0;
            src_q   <= '0;
            dst_q   <= '0;
            err     <= 1'b0;
            oa      <= '0;
            wa      <= '0;
            ack     <= '0;
            busy    <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            err     <= err_d;
            oa      <= oa_d;
            wa      <= wa_d;
            ack     <= ack_d;
            busy    <= busy_d;
        end
    end

endmodule

// File: doc/bus_xfer_ctrl.md
# bus_xfer_ctrl

Sequencer and arbiter for the shared 8-bit register bus. It accepts register-to-register transfer requests from several requesters, arbitrates them round-robin, and drives the one-hot output-enable (`oa`) and write-enable (`wa`) strobes of the bus-attached general-purpose registers. At most one source ever drives the bus in any cycle. The block sits between the CPU control unit and the register file; it never touches data itself.

## Interface
Parameters:
- `NREG`, default 8: number of registers on the bus.
- `NREQ`, default 4: number of requesters.
- `IW`, localparam `$clog2(NREG)`: width of a register index.

Ports:
- `clk`, in, 1: the single clock; all state updates on posedge.
- `clr_n`, in, 1: reset, asynchronous, active-low.
- `req`, in, NREQ: per-requester request level; held until that requester's `ack`.
- `src`, in, NREQ*IW: packed source indices; requester i uses bits [i*IW +: IW].
- `dst`, in, NREQ*IW: packed destination indices, same packing as `src`.
- `ack`, out, NREQ: one-cycle completion pulse to the granted requester.
- `oa`, out, NREG: one-hot register output enables.
- `wa`, out, NREG: one-hot register write enables.
- `busy`, out, 1: high in every non-IDLE state.
- `err`, out, 1: sticky flag for an out-of-range index; cleared only by reset.

## Operation
- FSM states are IDLE, DRIVE, WRITE and DONE. Outputs are registered and decoded from state plus the captured `src`/`dst`.
- **IDLE:**
  - `oa`, `wa` and `ack` are 0.
  - On a posedge with any `req` bit high, pick the winner by round-robin, capture its `src`/`dst`/grant index, and go to DRIVE.
- **DRIVE:** `oa[src]`=1 and `wa`=0 (the bus settles). Next state is WRITE.
- **WRITE:** `oa[src]`=1 and `wa[dst]`=1. The destination latches at the posedge ending this cycle. Next state is DONE.
- **DONE:** `oa`=`wa`=0 and `ack[grant]`=1. Next state is IDLE.
- **Round-robin:**
  - A pointer holds the last grant; the search starts at pointer+1 and wraps modulo NREQ.
  - The pointer resets to NREQ-1, so requester 0 wins first after reset.
  - The pointer updates only on grant.
- **src == dst:** the transfer runs normally. `wa[dst]` is still asserted (the register reloads itself), and `ack` is issued.
- **Index ≥ NREG** (possible only for non-power-of-2 NREG):
  - No enable is asserted for that index.
  - The FSM still walks all states and acks.
  - `err` is set at the grant edge.
- **Request changes after grant:** if `req` drops or `src`/`dst` change mid-transfer, the change is ignored because the captured values are used.
- **Requester rule:** a requester deasserts `req` on the posedge where it samples `ack`=1. If it keeps `req` high, that is treated as a new request.
- **Invariant:** `oa` and `wa` each have at most one bit set in every cycle.

## Timing
- **Reset values:** `oa`=0, `wa`=0, `ack`=0, `busy`=0, `err`=0, state=IDLE, pointer=NREQ-1.
- **Asynchronous reset:** `clr_n` low forces all outputs to 0 immediately, in any state. An in-flight transfer is abandoned with no `ack`.
- **Latency:** with `req` sampled high at posedge T:
  - DRIVE during T..T+1.
  - WRITE during T+1..T+2; the destination holds the new data after T+2.
  - `ack` high during T+2..T+3.
- **Throughput:** one transfer per 4 cycles under continuous load (the IDLE arbitration cycle is included).
- **Simultaneous requests:** resolved only by the round-robin pointer. A losing request waits and is served within NREQ transfers.

## Configuration
- **Macro:** `BUSXFER_NOSETTLE_EN`.
- **When defined:**
  - The DRIVE state is removed; IDLE goes directly to WRITE, where `oa` and `wa` are asserted together.
  - Latency: `ack` in cycle T+1..T+2.
  - Throughput: one transfer per 3 cycles.
- **When undefined:** the default 4-state behaviour above applies.

## Test plan
- **Reset mid-transfer:** reset, preload r2=0x5A, requester 0 requests src=2, dst=5; assert `clr_n` low during WRITE. Required: `oa`/`wa`/`busy` go to 0 asynchronously, no `ack`, and r5 is unchanged.
- **Single transfer:** reset, preload r1=0xA5, requester 0 requests src=1, dst=3. Required: `oa`=0x02 for two cycles, `wa`=0x08 for one cycle, `ack`=0001 at T+2, and r3 reads 0xA5.
- **Contention:** all 4 requesters request in the same cycle, each with a distinct src/dst. Required: grants come in order 0,1,2,3; `ack` pulses 16 cycles apart in total; no cycle has more than one `oa` bit set.
- **Fairness:** requesters 0 and 2 re-request continuously. Required: grants alternate 0,2,0,2, and neither is served twice in a row.
- **Self-copy and out-of-range:** a self-copy src=dst=4 acks with r4 unchanged. With NREG=6, src=7 gives `oa`=0, `ack` still issued, and `err`=1 until reset.
- **Macro build:** with `BUSXFER_NOSETTLE_EN` defined, repeat the single-transfer case. Required: `oa`=0x02 and `wa`=0x08 together for one cycle, `ack` at T+1, and r3 reads 0xA5.
